regfile_sb: RTL and testbench

//  Parametrised multi-read-port register file for the decode stage, with an integrated

---
 rtl/regfile_sb.sv | 130 +++++++++++++
 tb/tb_regfile_sb.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb -- decode-stage register file with a busy-bit scoreboard.
//
// Purpose:
//   Parametrised register file with NUM_RD combinational read ports, one
//   write-back port and a per-register busy scoreboard for RAW hazard
//   detection. Index PC_IDX is not stored: reads of it return i_pc_plus8,
//   and it is never written or marked busy.
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a write-back in progress is forwarded
//                      to any read port addressing the same register in the
//                      same cycle, and that port's hazard bit is suppressed.
//                      When undefined, reads return the stored value and the
//                      hazard holds until the cycle after write-back.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   i_we         write-back enable
//   i_wa         write-back address
//   i_wd         write-back data
//   i_pc_plus8   value returned for reads of PC_IDX
//   i_ra         packed read addresses, port i = i_ra[i*ADDR_W +: ADDR_W]
//   o_rd         packed read data,      port i = o_rd[i*DATA_W +: DATA_W]
//   i_iss_valid  instruction issued this cycle with a register destination
//   i_iss_dst    destination register of the issued instruction
//   o_hazard     bit i set when read port i addresses a busy register
//   o_stall      OR of the hazard bits
//   o_busy       scoreboard vector

module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int NUM_RD   = 2,
   parameter int PC_IDX   = 15,
   localparam int ADDR_W  = $clog2(NUM_REGS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_we,
   input  logic [ADDR_W-1:0]          i_wa,
   input  logic [DATA_W-1:0]          i_wd,
   input  logic [DATA_W-1:0]          i_pc_plus8,
   input  logic [NUM_RD*ADDR_W-1:0]   i_ra,
   output logic [NUM_RD*DATA_W-1:0]   o_rd,
   input  logic                       i_iss_valid,
   input  logic [ADDR_W-1:0]          i_iss_dst,
   output logic [NUM_RD-1:0]          o_hazard,
   output logic                       o_stall,
   output logic [NUM_REGS-1:0]        o_busy
);

   localparam logic [ADDR_W-1:0] PC_A   = ADDR_W'(PC_IDX);
   // One extra bit so NUM_REGS itself is representable for range checks.
   localparam logic [ADDR_W:0]   NREG_A = (ADDR_W+1)'(NUM_REGS);

   logic [DATA_W-1:0]   r_rf [NUM_REGS];
   logic [NUM_REGS-1:0] r_busy;

   // Storage. The PC_IDX slot is never written, so it stays at its reset
   // value and is optimised away; reads of it are redirected below.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            r_rf[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (i_we && i_wa == ADDR_W'(r) && r != PC_IDX) begin
               r_rf[r] <= i_wd;
            end
         end
      end
   end

   // Scoreboard. A new issue to r wins over a completing write-back to r:
   // the new producer is the one the next reader must wait for.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (r != PC_IDX) begin
               if (i_iss_valid && i_iss_dst == ADDR_W'(r)) begin
                  r_busy[r] <= 1'b1;
               end else if (i_we && i_wa == ADDR_W'(r)) begin
                  r_busy[r] <= 1'b0;
               end
            end
         end
      end
   end

   // Read ports.
   for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_rd;
      logic              w_haz;
      logic              w_in_range;

      assign w_ra       = i_ra[gi*ADDR_W +: ADDR_W];
      assign w_in_range = ({1'b0, w_ra} < NREG_A);

      always_comb begin
         w_rd  = '0;
         w_haz = 1'b0;
         if (w_ra == PC_A) begin
            w_rd = i_pc_plus8;
         end else if (w_in_range) begin
            w_rd  = r_rf[w_ra];
            w_haz = r_busy[w_ra];
`ifdef REGFILE_BYPASS_EN
            // Write-first forwarding: the completing value is visible now,
            // so the port no longer needs to wait for it.
            if (i_we && i_wa == w_ra) begin
               w_rd  = i_wd;
               w_haz = 1'b0;
            end
`endif
         end
      end

      assign o_rd[gi*DATA_W +: DATA_W] = w_rd;
      assign o_hazard[gi]              = w_haz;
   end

   assign o_stall = |o_hazard;
   assign o_busy  = r_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: table-driven vectors on the default
// configuration plus hand-written sequences for asynchronous reset and a
// second, narrower parameter set.

module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif

   // ---------------- default instance: 32b x 16 regs, 2 read ports ------
   logic        clk;
   logic        rst_n;
   logic        we;
   logic [3:0]  wa;
   logic [31:0] wd;
   logic [31:0] pc8;
   logic [7:0]  ra;
   logic [63:0] rd;
   logic        iv;
   logic [3:0]  dst;
   logic [1:0]  haz;
   logic        stall;
   logic [15:0] busy;

   regfile_sb dut (
      .clk(clk), .rst_n(rst_n), .i_we(we), .i_wa(wa), .i_wd(wd),
      .i_pc_plus8(pc8), .i_ra(ra), .o_rd(rd), .i_iss_valid(iv),
      .i_iss_dst(dst), .o_hazard(haz), .o_stall(stall), .o_busy(busy)
   );

   // ---------------- narrow instance: 16b x 8 regs, 3 read ports --------
   logic        we2;
   logic [2:0]  wa2;
   logic [15:0] wd2;
   logic [15:0] pc2;
   logic [8:0]  ra2;
   logic [47:0] rd2;
   logic        iv2;
   logic [2:0]  dst2;
   logic [2:0]  haz2;
   logic        stall2;
   logic [7:0]  busy2;

   regfile_sb #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(3), .PC_IDX(7)) dut2 (
      .clk(clk), .rst_n(rst_n), .i_we(we2), .i_wa(wa2), .i_wd(wd2),
      .i_pc_plus8(pc2), .i_ra(ra2), .o_rd(rd2), .i_iss_valid(iv2),
      .i_iss_dst(dst2), .o_hazard(haz2), .o_stall(stall2), .o_busy(busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Inputs applied for one cycle; expectations are the combinational
   // outputs sampled before the clock edge that consumes those inputs.
   typedef struct {
      logic        we;
      logic [3:0]  wa;
      logic [31:0] wd;
      logic [3:0]  ra0;
      logic [3:0]  ra1;
      logic        iv;
      logic [3:0]  dst;
      logic [31:0] e_rd0;
      logic [31:0] e_rd1;
      logic [1:0]  e_haz;
      logic [15:0] e_busy;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   initial begin
      //                we    wa     wd            ra0    ra1    iv    dst    e_rd0                               e_rd1                              e_haz                         e_busy
      // write r4 (not busy: legal, busy stays 0)
      vecs[0]  = '{1'b1, 4'd4,  32'hDEADBEEF, 4'd4,  4'd15, 1'b0, 4'd0,  BP ? 32'hDEADBEEF : 32'h0,       32'h108,                           2'b00,                        16'h0000};
      // write to PC index ignored, PC read still pc_plus8
      vecs[1]  = '{1'b1, 4'd15, 32'h5,        4'd4,  4'd15, 1'b0, 4'd0,  32'hDEADBEEF,                    32'h108,                           2'b00,                        16'h0000};
      // issue to r7
      vecs[2]  = '{1'b0, 4'd0,  32'h0,        4'd4,  4'd7,  1'b1, 4'd7,  32'hDEADBEEF,                    32'h0,                             2'b00,                        16'h0000};
      // r7 busy -> hazard on port 1
      vecs[3]  = '{1'b0, 4'd0,  32'h0,        4'd4,  4'd7,  1'b0, 4'd0,  32'hDEADBEEF,                    32'h0,                             2'b10,                        16'h0080};
      // write-back r7
      vecs[4]  = '{1'b1, 4'd7,  32'h77,       4'd4,  4'd7,  1'b0, 4'd0,  32'hDEADBEEF,                    BP ? 32'h77 : 32'h0,               BP ? 2'b00 : 2'b10,           16'h0080};
      // r7 cleared, both ports read the same value
      vecs[5]  = '{1'b0, 4'd0,  32'h0,        4'd7,  4'd7,  1'b0, 4'd0,  32'h77,                          32'h77,                            2'b00,                        16'h0000};
      // issue and write-back to r9 in the same cycle
      vecs[6]  = '{1'b1, 4'd9,  32'h99,       4'd9,  4'd4,  1'b1, 4'd9,  BP ? 32'h99 : 32'h0,             32'hDEADBEEF,                      2'b00,                        16'h0000};
      // set won: r9 busy on both ports
      vecs[7]  = '{1'b0, 4'd0,  32'h0,        4'd9,  4'd9,  1'b0, 4'd0,  32'h99,                          32'h99,                            2'b11,                        16'h0200};
      // issue to r2
      vecs[8]  = '{1'b0, 4'd0,  32'h0,        4'd2,  4'd15, 1'b1, 4'd2,  32'h0,                           32'h108,                           2'b00,                        16'h0200};
      // write-back r9 while r2 busy
      vecs[9]  = '{1'b1, 4'd9,  32'h9A,       4'd2,  4'd9,  1'b0, 4'd0,  32'h0,                           BP ? 32'h9A : 32'h99,              BP ? 2'b01 : 2'b11,           16'h0204};
      // write-back r2 while read on port 0
      vecs[10] = '{1'b1, 4'd2,  32'h55,       4'd2,  4'd9,  1'b0, 4'd0,  BP ? 32'h55 : 32'h0,             32'h9A,                            BP ? 2'b00 : 2'b01,           16'h0004};
      // issue to PC index: never marked busy
      vecs[11] = '{1'b0, 4'd0,  32'h0,        4'd2,  4'd15, 1'b1, 4'd15, 32'h55,                          32'h108,                           2'b00,                        16'h0000};
      vecs[12] = '{1'b0, 4'd0,  32'h0,        4'd15, 4'd2,  1'b0, 4'd0,  32'h108,                         32'h55,                            2'b00,                        16'h0000};
   end

   initial begin
      rst_n = 1'b0;
      we = 1'b0; wa = '0; wd = '0; pc8 = 32'h108; iv = 1'b0; dst = '0;
      ra = {4'd15, 4'd3};
      we2 = 1'b0; wa2 = '0; wd2 = '0; pc2 = 16'hBEEF; iv2 = 1'b0; dst2 = '0;
      ra2 = {3'd7, 3'd3, 3'd0};

      // Reset state.
      #2;
      chk("reset_rd0", rd[31:0], 32'h0);
      chk("reset_rd1_pc", rd[63:32], 32'h108);
      chk("reset_busy", {16'h0, busy}, 32'h0);
      chk("reset_stall", {31'h0, stall}, 32'h0);
      chk("reset2_rd", {16'h0, rd2[15:0]}, 32'h0);
      chk("reset2_rd_pc", {16'h0, rd2[47:32]}, 32'hBEEF);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven vectors.
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
         ra = {vecs[i].ra1, vecs[i].ra0};
         iv = vecs[i].iv; dst = vecs[i].dst;
         #1;
         chk($sformatf("v%0d_rd0", i), rd[31:0], vecs[i].e_rd0);
         chk($sformatf("v%0d_rd1", i), rd[63:32], vecs[i].e_rd1);
         chk($sformatf("v%0d_hazard", i), {30'h0, haz}, {30'h0, vecs[i].e_haz});
         chk($sformatf("v%0d_stall", i), {31'h0, stall}, {31'h0, |vecs[i].e_haz});
         chk($sformatf("v%0d_busy", i), {16'h0, busy}, {16'h0, vecs[i].e_busy});
         $display("vec %0d: ra={%0d,%0d} rd0=0x%0h rd1=0x%0h haz=%b busy=0x%0h",
                  i, vecs[i].ra1, vecs[i].ra0, rd[31:0], rd[63:32], haz, busy);
      end

      // Asynchronous reset mid-run: load r3 and mark it busy, then reset
      // between clock edges.
      @(negedge clk);
      we = 1'b1; wa = 4'd3; wd = 32'h33; iv = 1'b1; dst = 4'd3;
      @(negedge clk);
      we = 1'b0; iv = 1'b0; ra = {4'd15, 4'd3};
      #1;
      chk("pre_reset_rd0", rd[31:0], 32'h33);
      chk("pre_reset_busy", {16'h0, busy}, 32'h0008);
      chk("pre_reset_stall", {31'h0, stall}, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rd0", rd[31:0], 32'h0);
      chk("async_rd1_pc", rd[63:32], 32'h108);
      chk("async_busy", {16'h0, busy}, 32'h0);
      chk("async_stall", {31'h0, stall}, 32'h0);
      $display("async reset: rd0=0x%0h rd1=0x%0h busy=0x%0h stall=%b",
               rd[31:0], rd[63:32], busy, stall);
      @(negedge clk);
      rst_n = 1'b1;

      // Narrow configuration: 16-bit data, 8 registers, 3 read ports.
      @(negedge clk);
      we2 = 1'b1; wa2 = 3'd3; wd2 = 16'h1234;
      @(negedge clk);
      we2 = 1'b1; wa2 = 3'd7; wd2 = 16'hFFFF; iv2 = 1'b1; dst2 = 3'd7;
      ra2 = {3'd3, 3'd3, 3'd3};
      #1;
      chk("n_rd0", {16'h0, rd2[15:0]}, 32'h1234);
      chk("n_rd1", {16'h0, rd2[31:16]}, 32'h1234);
      chk("n_rd2", {16'h0, rd2[47:32]}, 32'h1234);
      $display("narrow write r3: rd={0x%0h,0x%0h,0x%0h}", rd2[47:32], rd2[31:16], rd2[15:0]);
      @(negedge clk);
      we2 = 1'b0; iv2 = 1'b0; ra2 = {3'd7, 3'd3, 3'd7};
      #1;
      chk("n_pc_rd0", {16'h0, rd2[15:0]}, 32'hBEEF);
      chk("n_rd1_keep", {16'h0, rd2[31:16]}, 32'h1234);
      chk("n_pc_rd2", {16'h0, rd2[47:32]}, 32'hBEEF);
      chk("n_busy_pc", {24'h0, busy2}, 32'h0);
      chk("n_hazard", {29'h0, haz2}, 32'h0);
      $display("narrow pc read: rd={0x%0h,0x%0h,0x%0h} busy=0x%0h",
               rd2[47:32], rd2[31:16], rd2[15:0], busy2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
